y_frame_serializer: RTL and testbench
=====================================

Name: y_frame_serializer

Overview:
- Consumer-side counterpart to the packed `y` result vector produced by the generated test designs.
- Accepts one 87-bit `y` snapshot per valid/ready handshake and streams it out LSB-first as 11 bytes, followed by an XOR checksum byte, on a byte-wide valid/ready link to the capture/compare host.
- Flags any snapshot whose constant pad bit `y[0]` is not 0, so that mis-packed results are caught at the boundary.

Parameters:
- `Y_WIDTH`, default 87: width of the incoming `y` vector.
- `NUM_BYTES`, default 11: data bytes per frame. Must equal ceil(`Y_WIDTH`/8). Unused MSBs of the last byte are zero-filled.
- `CHK_EN`, default 1: when 1, a checksum byte is appended after the data bytes; when 0, no checksum byte is sent.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `y_in` in `Y_WIDTH`: snapshot to serialize.
- `y_valid` in 1: `y_in` is valid.
- `y_ready` out 1: block can capture a snapshot.
- `tx_data` out 8: current output byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts `tx_data`.
- `tx_last` out 1: current byte is the last byte of the frame.
- `frame_cnt` out 16: count of completed frames.
- `pad_err` out 1: sticky pad-bit error flag.

Behaviour:
- Reset (`rst_n`=0 at a rising edge) gives: state IDLE, `y_ready`=1, `tx_valid`=0, `tx_last`=0, `tx_data`=0, `frame_cnt`=0, `pad_err`=0, shift register and checksum cleared.
- Reset mid-frame aborts the frame: no further bytes are sent and `frame_cnt` is not incremented.
- States:
  - IDLE: `y_ready`=1, `tx_valid`=0.
  - SEND: `tx_valid`=1; `tx_data` = shift register low byte.
  - CHK: `tx_valid`=1, `tx_data` = checksum, `tx_last`=1.
- Capture, IDLE -> SEND, when `y_valid`&`y_ready`:
  - Load `{zero pad, y_in}` (88 bits) into the shift register; clear the byte index and checksum.
  - If `y_in[0]`=1, set `pad_err`. `pad_err` clears only on reset.
- Latency: capture at edge N gives `tx_valid`=1 with byte 0 visible after edge N.
- In SEND, each handshake (`tx_valid`&`tx_ready`):
  - checksum ^= `tx_data`; shift register >>= 8; index++.
  - `tx_last`=1 on byte `NUM_BYTES`-1 only when `CHK_EN`=0.
- Frame end:
  - Byte `NUM_BYTES`-1 accepted: go to CHK if `CHK_EN`=1, else go to IDLE.
  - CHK byte accepted: go to IDLE.
  - Entering IDLE at frame end increments `frame_cnt` (wraps 0xFFFF -> 0x0000).
- Backpressure: while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_last`, state, index and checksum hold.
- `y_ready` is 0 in SEND and CHK. `y_valid` is ignored there and no snapshot is lost into the shift register.
- At least one IDLE cycle separates frames, so the frame rate is `NUM_BYTES`+2 cycles per frame at best with `CHK_EN`=1.
- `tx_ready` with `tx_valid`=0 has no effect.
- Checksum is 8-bit XOR over the data bytes only.

Test Plan:
1. Reset, then `y_in`=87'h0102, `y_valid` 1 cycle, `tx_ready`=1 -> bytes 02,01,00×9 then 03 with `tx_last`=1; `frame_cnt`=1; `pad_err`=0.
2. `y_in`=all ones -> bytes FF×10, 7F, checksum 7F; `pad_err`=1 and stays 1 across a following frame with `y_in[0]`=0; cleared only by reset.
3. Frame from scenario 1 with `tx_ready`=0 for 3 cycles while byte 4 is presented -> `tx_data`=00 and `tx_valid`=1 held for those 3 cycles; byte sequence and checksum unchanged.
4. `rst_n`=0 for 1 cycle after byte 5 is accepted -> next cycle `tx_valid`=0, `y_ready`=1, `frame_cnt`=0; a new frame then starts from byte 0.
5. `y_valid` held high with a changing `y_in` during SEND -> `y_ready`=0 and the frame carries only the captured value; a second capture occurs on the first IDLE cycle.
6. `CHK_EN`=0 build, `y_in`=87'h0102 -> 11 bytes with `tx_last` on byte 11 (01..00 pattern), no checksum byte; `frame_cnt`=1.

Source files
------------

// File: rtl/y_frame_serializer.sv
// Captures one Y_WIDTH-bit snapshot per handshake and streams it LSB-first as NUM_BYTES bytes.
// When CHK_EN is set, an XOR checksum byte follows the data bytes. The pad bit y_in[0] is checked.
module y_frame_serializer #(
  parameter int unsigned Y_WIDTH   = 87,
  parameter int unsigned NUM_BYTES = 11,
  parameter bit          CHK_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               y_valid,
  output logic               y_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [15:0]        frame_cnt,
  output logic               pad_err
);

  localparam int unsigned SrW  = NUM_BYTES * 8;
  localparam int unsigned IdxW = $clog2(NUM_BYTES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StChk} state_e;

  state_e          state_q, state_d;
  logic [SrW-1:0]  shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            pad_err_q, pad_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      frame_cnt_q <= '0;
      pad_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      frame_cnt_q <= frame_cnt_d;
      pad_err_q   <= pad_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    frame_cnt_d = frame_cnt_q;
    pad_err_d   = pad_err_q;
    y_ready     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    tx_last     = 1'b0;

    unique case (state_q)
      StIdle: begin
        y_ready = 1'b1;
        if (y_valid) begin
          // Zero-extend so the unused MSBs of the last byte go out as zero.
          shift_d = SrW'(y_in);
          idx_d   = '0;
          chk_d   = 8'h00;
          state_d = StSend;
          if (y_in[0]) begin
            pad_err_d = 1'b1;
          end
        end
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
        tx_last  = !CHK_EN && (idx_q == LastIdx);
        if (tx_ready) begin
          chk_d   = chk_q ^ shift_q[7:0];
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            if (CHK_EN) begin
              state_d = StChk;
            end else begin
              state_d     = StIdle;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
      end
      StChk: begin
        tx_valid = 1'b1;
        tx_data  = chk_q;
        tx_last  = 1'b1;
        if (tx_ready) begin
          state_d     = StIdle;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_cnt = frame_cnt_q;
  assign pad_err   = pad_err_q;

endmodule

// File: tb/tb_y_frame_serializer.sv
// Directed bench for y_frame_serializer: a checksum build and a CHK_EN=0 build side by side.
module tb_y_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [86:0] y_in;
  logic        y_valid, y_valid_nc;
  logic        tx_ready, tx_ready_nc;
  logic        y_ready, tx_valid, tx_last, pad_err;
  logic [7:0]  tx_data;
  logic [15:0] frame_cnt;
  logic        y_ready_nc, tx_valid_nc, tx_last_nc, pad_err_nc;
  logic [7:0]  tx_data_nc;
  logic [15:0] frame_cnt_nc;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_b [0:11];

  always #5 clk = ~clk;

  y_frame_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .frame_cnt (frame_cnt),
    .pad_err   (pad_err)
  );

  y_frame_serializer #(.CHK_EN(1'b0)) dut_nc (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .y_valid   (y_valid_nc),
    .y_ready   (y_ready_nc),
    .tx_data   (tx_data_nc),
    .tx_valid  (tx_valid_nc),
    .tx_ready  (tx_ready_nc),
    .tx_last   (tx_last_nc),
    .frame_cnt (frame_cnt_nc),
    .pad_err   (pad_err_nc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected frame: LSB-first bytes of the zero-padded snapshot, then their XOR.
  function automatic void build_exp(input logic [86:0] y);
    logic [87:0] v;
    logic [7:0]  c;
    v = {1'b0, y};
    c = 8'h00;
    for (int i = 0; i < 11; i++) begin
      exp_b[i] = v[8*i +: 8];
      c ^= exp_b[i];
    end
    exp_b[11] = c;
  endfunction

  task automatic chk_byte(input string tag, input int i);
    chk($sformatf("%s valid[%0d]", tag, i), {31'd0, tx_valid}, 32'd1);
    chk($sformatf("%s data[%0d]", tag, i), {24'd0, tx_data}, {24'd0, exp_b[i]});
    chk($sformatf("%s last[%0d]", tag, i), {31'd0, tx_last}, {31'd0, (i == 11)});
    chk($sformatf("%s y_ready[%0d]", tag, i), {31'd0, y_ready}, 32'd0);
  endtask

  task automatic capture(input logic [86:0] y);
    y_in    = y;
    y_valid = 1'b1;
    chk("capture y_ready", {31'd0, y_ready}, 32'd1);
    tick();
    y_valid = 1'b0;
    build_exp(y);
  endtask

  // Accept all 12 bytes, optionally stalling stall_len cycles while byte stall_at is shown.
  task automatic drain(input string tag, input int stall_at, input int stall_len);
    for (int i = 0; i < 12; i++) begin
      if (i == stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk_byte({tag, " stall"}, i);
        end
        tx_ready = 1'b1;
      end
      chk_byte(tag, i);
      tick();
    end
    chk({tag, " idle tx_valid"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; y_in = '0; y_valid = 1'b0; y_valid_nc = 1'b0;
    tx_ready = 1'b0; tx_ready_nc = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst y_ready", {31'd0, y_ready}, 32'd1);
    chk("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst tx_last", {31'd0, tx_last}, 32'd0);
    chk("rst tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst pad_err", {31'd0, pad_err}, 32'd0);
    tx_ready = 1'b1;

    // 1: basic frame
    capture(87'h0102);
    chk("s1 chk byte", {24'd0, exp_b[11]}, 32'h03);
    drain("s1", -1, 0);
    chk("s1 frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("s1 pad_err", {31'd0, pad_err}, 32'd0);

    // 2: all ones, sticky pad error
    capture({87{1'b1}});
    chk("s2 byte10", {24'd0, exp_b[10]}, 32'h7F);
    chk("s2 chk byte", {24'd0, exp_b[11]}, 32'h7F);
    drain("s2", -1, 0);
    chk("s2 pad_err", {31'd0, pad_err}, 32'd1);
    capture(87'h5a5a_a5a4);
    drain("s2b", -1, 0);
    chk("s2b pad_err sticky", {31'd0, pad_err}, 32'd1);
    chk("s2b frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // 3: backpressure on byte 4
    capture(87'h0102);
    drain("s3", 4, 3);
    chk("s3 frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // 4: reset mid-frame after byte 5 accepted
    capture(87'h0102);
    for (int i = 0; i < 6; i++) begin
      chk_byte("s4", i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s4 tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("s4 y_ready", {31'd0, y_ready}, 32'd1);
    chk("s4 frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("s4 pad_err", {31'd0, pad_err}, 32'd0);
    tick();
    chk("s4 idle tx_valid", {31'd0, tx_valid}, 32'd0);
    capture(87'h0102);
    drain("s4b", -1, 0);
    chk("s4b frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 5: y_valid held with changing y_in during SEND
    y_in    = 87'h1234_5678_9abc_def0;
    y_valid = 1'b1;
    tick();
    build_exp(87'h1234_5678_9abc_def0);
    y_in = 87'h00ab_cdef_0102_0304_0506;
    drain("s5a", -1, 0);
    chk("s5 y_ready idle", {31'd0, y_ready}, 32'd1);
    chk("s5a frame_cnt", {16'd0, frame_cnt}, 32'd2);
    tick();
    y_valid = 1'b0;
    build_exp(87'h00ab_cdef_0102_0304_0506);
    drain("s5b", -1, 0);
    chk("s5b frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // 6: CHK_EN=0 build
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    y_in       = 87'h0102;
    y_valid_nc = 1'b1;
    chk("s6 y_ready", {31'd0, y_ready_nc}, 32'd1);
    tick();
    y_valid_nc  = 1'b0;
    tx_ready_nc = 1'b1;
    build_exp(87'h0102);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("s6 valid[%0d]", i), {31'd0, tx_valid_nc}, 32'd1);
      chk($sformatf("s6 data[%0d]", i), {24'd0, tx_data_nc}, {24'd0, exp_b[i]});
      chk($sformatf("s6 last[%0d]", i), {31'd0, tx_last_nc}, {31'd0, (i == 10)});
      tick();
    end
    chk("s6 no chk byte", {31'd0, tx_valid_nc}, 32'd0);
    chk("s6 frame_cnt", {16'd0, frame_cnt_nc}, 32'd1);
    chk("s6 pad_err", {31'd0, pad_err_nc}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
